wb_write_arbiter: RTL and testbench

//   Write-back side of the GPR file. Merges results from two producers onto the

---
 rtl/wb_write_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - GPR write-back arbiter merging port A and FIFO-buffered port B (optional WB_SCOREBOARD_EN pending-bit scoreboard)
module wb_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid_i,
    input  logic [ADDR_W-1:0] a_waddr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [ADDR_W-1:0] b_waddr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stall_o
`ifdef WB_SCOREBOARD_EN
    ,
    input  logic                 iss_valid_i,
    input  logic [ADDR_W-1:0]    iss_addr_i,
    output logic [2**ADDR_W-1:0] pend_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SW    = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2
    } sel_e;

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_d [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [DATA_W-1:0] mem_data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              stall_q, stall_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic fifo_empty;
    logic fifo_full;
    logic a_hit;
    logic push;
    logic pop;
    sel_e sel;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(DEPTH));
        a_hit      = a_valid_i && (a_waddr_i != '0);
        b_ready_o  = !rst && !fifo_full;
        // Writes to x0 complete the handshake but never occupy a slot.
        push       = b_valid_i && b_ready_o && (b_waddr_i != '0);
        if (a_hit) begin
            sel = SEL_A;
        end else if (!fifo_empty) begin
            sel = SEL_B;
        end else begin
            sel = SEL_NONE;
        end
        pop = (sel == SEL_B);
    end

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_addr_d[wr_ptr_q] = b_waddr_i;
            mem_data_d[wr_ptr_q] = b_wdata_i;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        we_d    = (sel != SEL_NONE);
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (sel)
            SEL_A: begin
                waddr_d = a_waddr_i;
                wdata_d = a_wdata_i;
            end
            SEL_B: begin
                waddr_d = mem_addr_q[rd_ptr_q];
                wdata_d = mem_data_q[rd_ptr_q];
            end
            default: ;
        endcase

        // Counts cycles the head waits; a pop or an empty FIFO restarts it.
        starve_d = '0;
        if (!pop && !fifo_empty) begin
            if (starve_q != SW'(STARVE_MAX)) begin
                starve_d = starve_q + SW'(1);
            end else begin
                starve_d = starve_q;
            end
        end
        stall_d = (starve_d == SW'(STARVE_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign stall_o = stall_q;

`ifdef WB_SCOREBOARD_EN
    logic                 we_b_q, we_b_d;
    logic [2**ADDR_W-1:0] pend_q, pend_d;

    // Clear follows the registered B commit; a new issue the same cycle wins.
    always_comb begin
        we_b_d = pop;
        pend_d = pend_q;
        if (we_q && we_b_q) begin
            pend_d[waddr_q] = 1'b0;
        end
        if (iss_valid_i && (iss_addr_i != '0)) begin
            pend_d[iss_addr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_b_q <= 1'b0;
            pend_q <= '0;
        end else begin
            we_b_q <= we_b_d;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - randomized and directed self-checking bench for wb_write_arbiter
module tb_wb_write_arbiter;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 8;

    logic              clk;
    logic              rst;
    logic              a_valid_i;
    logic [ADDR_W-1:0] a_waddr_i;
    logic [DATA_W-1:0] a_wdata_i;
    logic              b_valid_i;
    logic              b_ready_o;
    logic [ADDR_W-1:0] b_waddr_i;
    logic [DATA_W-1:0] b_wdata_i;
    logic              we_o;
    logic [ADDR_W-1:0] waddr_o;
    logic [DATA_W-1:0] wdata_o;
    logic              stall_o;
`ifdef WB_SCOREBOARD_EN
    logic                 iss_valid_i;
    logic [ADDR_W-1:0]    iss_addr_i;
    logic [2**ADDR_W-1:0] pend_o;
    logic [2**ADDR_W-1:0] m_pend;
`endif

    wb_write_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid_i(a_valid_i), .a_waddr_i(a_waddr_i), .a_wdata_i(a_wdata_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .b_waddr_i(b_waddr_i), .b_wdata_i(b_wdata_i),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .stall_o(stall_o)
`ifdef WB_SCOREBOARD_EN
        , .iss_valid_i(iss_valid_i), .iss_addr_i(iss_addr_i), .pend_o(pend_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: queue of pending B beats plus a wait counter.
    logic [ADDR_W+DATA_W-1:0] q[$];
    logic              m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_srcb;
    int                m_starve;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_we     = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
        m_srcb   = 1'b0;
        m_starve = 0;
`ifdef WB_SCOREBOARD_EN
        m_pend   = '0;
`endif
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
`ifdef WB_SCOREBOARD_EN
        iss_valid_i = 1'b0;
`endif
        #1;
        check("rst_we", we_o, 0);
        check("rst_waddr", waddr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_b_ready", b_ready_o, 0);
`ifdef WB_SCOREBOARD_EN
        check("rst_pend", pend_o, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic step(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                        input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                        input logic iv, input logic [ADDR_W-1:0] ia);
        int pre;
        bit acc;
        bit popped;
        logic [ADDR_W+DATA_W-1:0] e;
        a_valid_i = av; a_waddr_i = aa; a_wdata_i = ad;
        b_valid_i = bv; b_waddr_i = ba; b_wdata_i = bd;
`ifdef WB_SCOREBOARD_EN
        iss_valid_i = iv; iss_addr_i = ia;
`endif
        #1;
        check("b_ready", b_ready_o, q.size() < DEPTH);
        pre = q.size();
        acc = bv && (pre < DEPTH);
        popped = 1'b0;
        @(posedge clk);
`ifdef WB_SCOREBOARD_EN
        if (m_we && m_srcb) m_pend[m_waddr] = 1'b0;
        if (iv && ia != 0) m_pend[ia] = 1'b1;
        m_pend[0] = 1'b0;
`endif
        if (av && aa != 0) begin
            m_we = 1'b1; m_waddr = aa; m_wdata = ad; m_srcb = 1'b0;
        end else if (pre > 0) begin
            e = q.pop_front();
            m_we = 1'b1; m_waddr = e[ADDR_W+DATA_W-1:DATA_W]; m_wdata = e[DATA_W-1:0];
            m_srcb = 1'b1; popped = 1'b1;
        end else begin
            m_we = 1'b0; m_srcb = 1'b0;
        end
        if (popped) m_starve = 0;
        else if (pre > 0) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
        else m_starve = 0;
        if (acc && ba != 0) q.push_back({ba, bd});
        #1;
        check("we", we_o, m_we);
        check("waddr", waddr_o, m_waddr);
        check("wdata", wdata_o, m_wdata);
        check("stall", stall_o, m_starve == STARVE_MAX);
`ifdef WB_SCOREBOARD_EN
        check("pend", pend_o, m_pend);
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        a_valid_i = 0; a_waddr_i = 0; a_wdata_i = 0;
        b_valid_i = 0; b_waddr_i = 0; b_wdata_i = 0;
`ifdef WB_SCOREBOARD_EN
        iss_valid_i = 0; iss_addr_i = 0;
`endif
        model_clear();
        @(posedge clk);
        #1;
        do_reset();
        idle();

        // T2: A only
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        check("t2_we", we_o, 1);
        check("t2_data", wdata_o, 32'hDEADBEEF);
        step(1, 0, 32'h12345678, 0, 0, 0, 0, 0);
        check("t2_zero_we", we_o, 0);

        // T3: contention with A busy every cycle
        step(1, 3, 32'h1, 1, 7, 32'h700, 1, 12);
        step(1, 3, 32'h2, 1, 8, 32'h800, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 3, 32'h10 + i, 1, 10, 32'hA00, 0, 0);
        check("t3_b_ready", b_ready_o, 0);
        check("t3_stall", stall_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("t3_first", waddr_o, 7);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("t3_second", waddr_o, 8);
        check("t3_stall_clr", stall_o, 0);
        idle();

        // T4: A with addr 0 yields the slot to B
        step(1, 3, 32'h3, 1, 9, 32'h900, 0, 0);
        step(1, 0, 32'h4, 0, 0, 0, 0, 0);
        check("t4_we", we_o, 1);
        check("t4_addr", waddr_o, 9);

        // T5: B to x0 is accepted and dropped
        step(0, 0, 0, 1, 0, 32'hBAD, 0, 0);
        idle();
        check("t5_we", we_o, 0);

        // T6: scoreboard set/clear, set wins on collision
        step(0, 0, 0, 1, 12, 32'hC0, 1, 12);
        step(0, 0, 0, 1, 12, 32'hC1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 12);
        idle();
        idle();

        // T1: reset mid-burst with two entries queued
        step(1, 4, 32'h5, 1, 20, 32'h14, 0, 0);
        step(1, 4, 32'h6, 1, 21, 32'h15, 0, 0);
        do_reset();
        idle();
        check("t1_no_write", we_o, 0);
        check("t1_b_ready", b_ready_o, 1);

        // Randomized traffic with an occasional reset
        for (int n = 0; n < 3000; n++) begin
            logic av, bv, iv;
            logic [ADDR_W-1:0] aa, ba, ia;
            av = ($urandom_range(0, 9) < 6);
            bv = ($urandom_range(0, 9) < 5);
            iv = ($urandom_range(0, 9) < 3);
            aa = ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom);
            ba = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
            ia = ADDR_W'($urandom);
            if ((n % 400) < 40) av = 1'b1;
            if (n % 997 == 500) do_reset();
            step(av, aa, $urandom, bv, ba, $urandom, iv, ia);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
